// File: rtl/mips_pc_pkg.sv
// Shared definitions for the fetch-address sequencer.
//   pc_src_e            : which source supplies the next fetch address
//   EXC_VECTOR_DEFAULT  : default exception entry address (32-bit, zero-extended by users)
//   WORD_SHIFT          : branch offsets are in words; shift by this to get bytes
package mips_pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RET,
    SRC_EXC,
    SRC_ERET
  } pc_src_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
  localparam int          WORD_SHIFT         = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk          : rising-edge clock
//   rst_ni       : synchronous active-low reset (empties the stack)
//   push_i       : push push_data_i (overwrites the oldest entry when full)
//   pop_i        : pop the top entry (ignored when empty, flags underflow)
//   push_data_i  : return address to store
//   top_o        : current top entry (combinational)
//   empty_o      : no valid entries
//   count_o      : number of valid entries
//   overflow_o   : registered pulse, push happened while full
//   underflow_o  : registered pulse, pop requested while empty
module pc_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_W-1:0]            push_data_i,
  output logic [ADDR_W-1:0]            top_o,
  output logic                         empty_o,
  output logic [$clog2(RAS_DEPTH):0]   count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q;      // next free slot; when full it points at the oldest entry
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              of_q;
  logic              uf_q;
  logic              full;

  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty_o = (cnt_q == '0);
  // Depth is a power of two, so the pointer wraps naturally.
  assign top_ptr = sp_q - 1'b1;
  assign top_o   = stack_q[top_ptr];

  // Entries carry no reset: validity is tracked by cnt_q alone.
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_i && (sp_q == PTR_W'(gi))) begin
          stack_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      of_q <= push_i && full;
      uf_q <= pop_i && empty_o;
      if (push_i) begin
        sp_q <= sp_q + 1'b1;
        if (!full) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (pop_i && !empty_o) begin
        sp_q  <= sp_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign count_o     = cnt_q;
  assign overflow_o  = of_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of the fetch path.
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   stall               : freeze PC, EPC and RAS (exceptions still taken)
//   field_addr16/26     : branch word offset / jump index
//   jr_target           : register target (jr/jalr, empty-RAS return fallback)
//   branch_en/inv, zero_flag, jump_en, jr_en, link_en, ret_en, exc_en, eret_en
//                       : redirect requests, priority exc > eret > ret > jr > jump > branch
//   pc_out, pc_plus4    : current fetch address and its sequential successor
//   epc_out             : saved exception PC
//   ras_count           : valid return-stack entries
//   ras_underflow/ras_overflow/target_misaligned : registered one-cycle pulses
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]       EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [15:0]                field_addr16,
  input  logic [25:0]                field_addr26,
  input  logic [ADDR_W-1:0]          jr_target,
  input  logic                       branch_en,
  input  logic                       branch_inv,
  input  logic                       zero_flag,
  input  logic                       jump_en,
  input  logic                       jr_en,
  input  logic                       link_en,
  input  logic                       ret_en,
  input  logic                       exc_en,
  input  logic                       eret_en,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [ADDR_W-1:0]          pc_plus4,
  output logic [ADDR_W-1:0]          epc_out,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_underflow,
  output logic                       ras_overflow,
  output logic                       target_misaligned
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              mis_q, mis_d;

  pc_src_e           src;
  logic              hold;
  logic              branch_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_aligned;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_push;
  logic              ras_pop;

  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign branch_taken = branch_en && (branch_inv ? !zero_flag : zero_flag);
  assign br_target    = pc_plus4 + (ADDR_W'($signed(field_addr16)) << WORD_SHIFT);
  assign j_target     = {pc_plus4[ADDR_W-1:28], field_addr26, 2'b00};
  assign jr_aligned   = {jr_target[ADDR_W-1:2], 2'b00};

  // Source selection. A stall without an exception drops every request.
  always_comb begin
    src  = SRC_SEQ;
    hold = 1'b0;
    if (exc_en)            src  = SRC_EXC;
    else if (stall)        hold = 1'b1;
    else if (eret_en)      src  = SRC_ERET;
    else if (ret_en)       src  = SRC_RET;
    else if (jr_en)        src  = SRC_JR;
    else if (jump_en)      src  = SRC_J;
    else if (branch_taken) src  = SRC_BR;
  end

  always_comb begin
    pc_d = pc_plus4;
    case (src)
      SRC_BR:   pc_d = br_target;
      SRC_J:    pc_d = j_target;
      SRC_JR:   pc_d = jr_aligned;
      SRC_RET:  pc_d = ras_empty ? jr_aligned : ras_top;
      SRC_EXC:  pc_d = ADDR_W'(EXC_VECTOR);
      SRC_ERET: pc_d = epc_q;
      default:  pc_d = pc_plus4;
    endcase
    if (hold) begin
      pc_d = pc_q;
    end
  end

  // The faulting instruction is the one currently being fetched.
  assign epc_d = (src == SRC_EXC) ? pc_q : epc_q;

  // Misalignment only matters when jr_target actually becomes the PC.
  assign mis_d = !hold && (jr_target[1:0] != 2'b00) &&
                 ((src == SRC_JR) || ((src == SRC_RET) && ras_empty));

  assign ras_push = !hold && link_en && ((src == SRC_J) || (src == SRC_JR));
  assign ras_pop  = !hold && (src == SRC_RET);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_ni      (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .count_o     (ras_count),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );

  assign pc_out            = pc_q;
  assign epc_out           = epc_q;
  assign target_misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [15:0] field_addr16;
  logic [25:0] field_addr26;
  logic [31:0] jr_target;
  logic        branch_en, branch_inv, zero_flag;
  logic        jump_en, jr_en, link_en, ret_en, exc_en, eret_en;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic [2:0]  ras_count;
  logic        ras_underflow, ras_overflow, target_misaligned;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0400),
    .EXC_VECTOR   (32'h8000_0180),
    .RAS_DEPTH    (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .field_addr16      (field_addr16),
    .field_addr26      (field_addr26),
    .jr_target         (jr_target),
    .branch_en         (branch_en),
    .branch_inv        (branch_inv),
    .zero_flag         (zero_flag),
    .jump_en           (jump_en),
    .jr_en             (jr_en),
    .link_en           (link_en),
    .ret_en            (ret_en),
    .exc_en            (exc_en),
    .eret_en           (eret_en),
    .pc_out            (pc_out),
    .pc_plus4          (pc_plus4),
    .epc_out           (epc_out),
    .ras_count         (ras_count),
    .ras_underflow     (ras_underflow),
    .ras_overflow      (ras_overflow),
    .target_misaligned (target_misaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        uf;
    logic        of;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  task automatic chk(input string what, input int txn, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, what, act, exp);
    end
  endtask

  task automatic clr();
    stall        = 1'b0;
    field_addr16 = '0;
    field_addr26 = '0;
    jr_target    = '0;
    branch_en    = 1'b0;
    branch_inv   = 1'b0;
    zero_flag    = 1'b0;
    jump_en      = 1'b0;
    jr_en        = 1'b0;
    link_en      = 1'b0;
    ret_en       = 1'b0;
    exc_en       = 1'b0;
    eret_en      = 1'b0;
  endtask

  // Apply the currently driven inputs for one edge and queue the expected result.
  task automatic step(input logic [31:0] e_pc, input logic [31:0] e_epc, input int e_cnt,
                      input logic e_uf, input logic e_of, input logic e_mis);
    exp_t e;
    e.pc  = e_pc;
    e.epc = e_epc;
    e.cnt = 3'(e_cnt);
    e.uf  = e_uf;
    e.of  = e_of;
    e.mis = e_mis;
    @(posedge clk);
    exp_q.push_back(e);
    pushed++;
    #2;
    clr();
  endtask

  // Monitor: every edge that has a queued expectation is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        $display("txn %0d pc=%h epc=%h cnt=%0d uf=%b of=%b mis=%b", popped, pc_out, epc_out,
                 ras_count, ras_underflow, ras_overflow, target_misaligned);
        chk("pc_out", popped, pc_out, e.pc);
        chk("epc_out", popped, epc_out, e.epc);
        chk("ras_count", popped, 32'(ras_count), 32'(e.cnt));
        chk("ras_underflow", popped, 32'(ras_underflow), 32'(e.uf));
        chk("ras_overflow", popped, 32'(ras_overflow), 32'(e.of));
        chk("target_misaligned", popped, 32'(target_misaligned), 32'(e.mis));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    reset = 1'b0;
    // Reset held two cycles, then free-running sequential fetch.
    step(32'h400, 0, 0, 0, 0, 0);
    step(32'h400, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(32'h404, 0, 0, 0, 0, 0);
    step(32'h408, 0, 0, 0, 0, 0);
    // Jump to 0x100.
    jump_en = 1; field_addr26 = 26'h40;
    step(32'h100, 0, 0, 0, 0, 0);
    // beq taken: 0x104 - 8.
    branch_en = 1; zero_flag = 1; field_addr16 = 16'hFFFE;
    step(32'h0FC, 0, 0, 0, 0, 0);
    jump_en = 1; field_addr26 = 26'h40;
    step(32'h100, 0, 0, 0, 0, 0);
    // bne with zero set: not taken.
    branch_en = 1; branch_inv = 1; zero_flag = 1; field_addr16 = 16'hFFFE;
    step(32'h104, 0, 0, 0, 0, 0);
    // Go to 0x1000, jal, then return.
    jump_en = 1; field_addr26 = 26'h400;
    step(32'h1000, 0, 0, 0, 0, 0);
    jump_en = 1; link_en = 1; field_addr26 = 26'h40;
    step(32'h100, 0, 1, 0, 0, 0);
    ret_en = 1;
    step(32'h1004, 0, 0, 0, 0, 0);
    // Five calls; the fifth overwrites the oldest entry.
    jump_en = 1; link_en = 1; field_addr26 = 26'h200;
    step(32'h800, 0, 1, 0, 0, 0);
    jump_en = 1; link_en = 1; field_addr26 = 26'h300;
    step(32'hC00, 0, 2, 0, 0, 0);
    jump_en = 1; link_en = 1; field_addr26 = 26'h400;
    step(32'h1000, 0, 3, 0, 0, 0);
    jump_en = 1; link_en = 1; field_addr26 = 26'h500;
    step(32'h1400, 0, 4, 0, 0, 0);
    jump_en = 1; link_en = 1; field_addr26 = 26'h600;
    step(32'h1800, 0, 4, 0, 1, 0);
    // Five returns; the fifth falls back to jr_target.
    ret_en = 1;
    step(32'h1404, 0, 3, 0, 0, 0);
    ret_en = 1;
    step(32'h1004, 0, 2, 0, 0, 0);
    ret_en = 1;
    step(32'hC04, 0, 1, 0, 0, 0);
    ret_en = 1;
    step(32'h804, 0, 0, 0, 0, 0);
    ret_en = 1; jr_target = 32'h2003;
    step(32'h2000, 0, 0, 1, 0, 1);
    // jalr aligned, then misaligned jr landing on 0x300.
    jr_en = 1; link_en = 1; jr_target = 32'h3000;
    step(32'h3000, 0, 1, 0, 0, 0);
    jr_en = 1; jr_target = 32'h301;
    step(32'h300, 0, 1, 0, 0, 1);
    // Stall drops jump and return requests.
    stall = 1; jump_en = 1; field_addr26 = 26'h999;
    step(32'h300, 0, 1, 0, 0, 0);
    stall = 1; ret_en = 1;
    step(32'h300, 0, 1, 0, 0, 0);
    // Exception taken even while stalled, then eret.
    stall = 1; exc_en = 1;
    step(32'h8000_0180, 32'h300, 1, 0, 0, 0);
    eret_en = 1;
    step(32'h300, 32'h300, 1, 0, 0, 0);
    // Exception beats jr and a taken branch.
    exc_en = 1; jr_en = 1; jr_target = 32'h5000; branch_en = 1; zero_flag = 1; field_addr16 = 16'h0010;
    step(32'h8000_0180, 32'h300, 1, 0, 0, 0);
    // Reset during a redirect.
    reset = 1'b0; jump_en = 1; field_addr26 = 26'h40;
    step(32'h400, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(32'h404, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    chk("all_expectations_consumed", 0, 32'(popped), 32'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
